// File: rtl/cla_seq_ctrl_if.sv
// Operand/result handshake bundle for cla_seq_ctrl.
// Optional subtract request line is present when CLA_SEQ_SUB_EN is defined.
interface cla_seq_ctrl_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
`ifdef CLA_SEQ_SUB_EN
    logic             op_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

`ifdef CLA_SEQ_SUB_EN
    modport master (
        output in_valid, in_a, in_b, in_cin, op_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, op_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
`endif
endinterface

// File: rtl/cla_seq_ctrl.sv
// Multi-cycle wide adder that time-shares one external 16-bit CLA slice.
// Chunks are fed LSB first, one per cycle, with the carry rippled in a register.
// Optional feature macro: CLA_SEQ_SUB_EN (adds op_sub for A-B).
module cla_seq_ctrl #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SLICE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cla_seq_ctrl_if.slave     bus,
    output logic              busy,
    output logic [SLICE-1:0]  add_a,
    output logic [SLICE-1:0]  add_b,
    output logic              add_cin,
    input  logic [SLICE-1:0]  add_s,
    input  logic              add_cout
);
    localparam int unsigned CHUNKS = WIDTH / SLICE;
    localparam int unsigned IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry;
    logic               accept;
    logic               last_chunk;
    int unsigned        base;

    assign accept     = (state == IDLE) && bus.in_valid;
    assign last_chunk = (idx == IDX_W'(CHUNKS - 1));
    assign base       = SLICE * 32'(idx);

    // Result bus shows the assembled sum and final carry, stable while in DONE.
    assign bus.out_sum  = sum_reg;
    assign bus.out_cout = carry;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: handshake flags and slice drive (slice inputs zero outside RUN).
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        add_a         = '0;
        add_b         = '0;
        add_cin       = 1'b0;
        case (state)
            IDLE: bus.in_ready = 1'b1;
            RUN: begin
                busy    = 1'b1;
                add_a   = a_reg[base +: SLICE];
                add_b   = b_reg[base +: SLICE];
                add_cin = carry;
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: capture operands on accept, collect one slice result per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= '0;
            carry   <= 1'b0;
            sum_reg <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= bus.in_a;
                        idx   <= '0;
`ifdef CLA_SEQ_SUB_EN
                        b_reg <= bus.op_sub ? ~bus.in_b : bus.in_b;
                        carry <= bus.op_sub ? 1'b1 : bus.in_cin;
`else
                        b_reg <= bus.in_b;
                        carry <= bus.in_cin;
`endif
                    end
                end
                RUN: begin
                    sum_reg[base +: SLICE] <= add_s;
                    carry                  <= add_cout;
                    if (!last_chunk) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Self-checking bench for cla_seq_ctrl (WIDTH=64) with a behavioural CLA16 slice.
module tb_cla_seq_ctrl;
    localparam int unsigned WIDTH = 64;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_s;
    logic        add_cout;
    logic [16:0] slice_res;

    cla_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cla_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // External 16-bit slice: purely combinational.
    assign slice_res = 17'(add_a) + 17'(add_b) + 17'(add_cin);
    assign add_s     = slice_res[15:0];
    assign add_cout  = slice_res[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_cin = cin;
`ifdef CLA_SEQ_SUB_EN
        bus.op_sub = sub;
`else
        if (sub) $display("note: subtract requested but feature not built");
`endif
    endtask

    // Issue one operation, wait (bounded) for the result; leaves DUT in DONE.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub,
                          output logic [63:0] sum, output logic cout, output int lat);
        drive_op(a, b, cin, sub);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        sum  = bus.out_sum;
        cout = bus.out_cout;
    endtask

    logic [63:0] r_sum;
    logic        r_cout;
    int          r_lat;
    logic [63:0] hold_sum;
    logic        hold_cout;
    int          seen;

    initial begin
        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
        vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 64'h2345_6789_ABCD_F002, 1'b0};
        vecs[4] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0};
        vecs[5] = '{64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_op(64'h0, 64'h0, 1'b0, 1'b0);
        step();
        step();

        // Reset state
        chk("rst in_ready",  65'(bus.in_ready),  65'd1);
        chk("rst out_valid", 65'(bus.out_valid), 65'd0);
        chk("rst out_sum",   65'(bus.out_sum),   65'd0);
        chk("rst out_cout",  65'(bus.out_cout),  65'd0);
        chk("rst busy",      65'(busy),          65'd0);
        chk("rst add_bus",   65'({add_a, add_b, add_cin}), 65'd0);
        rst_n = 1'b1;
        step();

        // Table-driven additions
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, r_sum, r_cout, r_lat);
            chk($sformatf("vec%0d latency", i), 65'(r_lat), 65'd4);
            chk($sformatf("vec%0d sum", i), 65'(r_sum), 65'(vecs[i].exp_sum));
            chk($sformatf("vec%0d cout", i), 65'(r_cout), 65'(vecs[i].exp_cout));
            step();
            chk($sformatf("vec%0d valid drop", i), 65'(bus.out_valid), 65'd0);
            chk($sformatf("vec%0d in_ready back", i), 65'(bus.in_ready), 65'd1);
        end

        // Backpressure: result held, new requests ignored
        bus.out_ready = 1'b0;
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, r_sum, r_cout, r_lat);
        chk("bp latency", 65'(r_lat), 65'd4);
        hold_sum  = r_sum;
        hold_cout = r_cout;
        drive_op(64'hDEAD_BEEF_0000_1111, 64'h1234, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp%0d out_valid", c), 65'(bus.out_valid), 65'd1);
            chk($sformatf("bp%0d sum", c), 65'(bus.out_sum), 65'h0000_0000_0001_0000);
            chk($sformatf("bp%0d cout", c), 65'(bus.out_cout), 65'(hold_cout));
            chk($sformatf("bp%0d in_ready", c), 65'(bus.in_ready), 65'd0);
        end
        chk("bp held sum", 65'(bus.out_sum), 65'(hold_sum));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp release valid", 65'(bus.out_valid), 65'd0);
        chk("bp release ready", 65'(bus.in_ready), 65'd1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus.out_valid) seen++;
        end
        chk("bp no ghost result", 65'(seen), 65'd0);

        // Reset during the second RUN cycle
        drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("mid busy", 65'(busy), 65'd1);
        step();
        rst_n = 1'b0;
        step();
        chk("mid rst in_ready",  65'(bus.in_ready),  65'd1);
        chk("mid rst out_valid", 65'(bus.out_valid), 65'd0);
        chk("mid rst add_bus",   65'({add_a, add_b, add_cin}), 65'd0);
        chk("mid rst busy",      65'(busy), 65'd0);
        rst_n = 1'b1;
        seen  = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus.out_valid) seen++;
        end
        chk("mid rst no result", 65'(seen), 65'd0);

        // Streaming: in_valid and out_ready held high, four random pairs
        begin
            logic [63:0] pa[4];
            logic [63:0] pb[4];
            logic        pc[4];
            logic [64:0] pexp[4];
            int          acc_cyc[4];
            int          k;
            int          n_out;
            int          cyc;
            for (int i = 0; i < 4; i++) begin
                pa[i]   = {$urandom, $urandom};
                pb[i]   = {$urandom, $urandom};
                pc[i]   = 1'($urandom_range(0, 1));
                pexp[i] = 65'(pa[i]) + 65'(pb[i]) + 65'(pc[i]);
            end
            k = 0;
            n_out = 0;
            cyc = 0;
            drive_op(pa[0], pb[0], pc[0], 1'b0);
            bus.in_valid = 1'b1;
            while (n_out < 4 && cyc < 100) begin
                if (bus.out_valid) begin
                    chk($sformatf("stream%0d result", n_out), {bus.out_cout, bus.out_sum}, pexp[n_out]);
                    n_out++;
                end
                if (bus.in_ready && bus.in_valid) begin
                    acc_cyc[k] = cyc;
                    k++;
                end
                step();
                cyc++;
                if (k < 4) drive_op(pa[k], pb[k], pc[k], 1'b0);
                else bus.in_valid = 1'b0;
            end
            chk("stream results count", 65'(n_out), 65'd4);
            for (int i = 1; i < k; i++) begin
                chk($sformatf("stream spacing%0d", i), 65'(acc_cyc[i] - acc_cyc[i-1]), 65'd6);
            end
            bus.in_valid = 1'b0;
            step();
            step();
        end

`ifdef CLA_SEQ_SUB_EN
        // Subtraction
        run_op(64'd5, 64'd7, 1'b0, 1'b1, r_sum, r_cout, r_lat);
        chk("sub 5-7 sum",  65'(r_sum),  65'hFFFF_FFFF_FFFF_FFFE);
        chk("sub 5-7 cout", 65'(r_cout), 65'd0);
        step();
        run_op(64'd7, 64'd5, 1'b0, 1'b1, r_sum, r_cout, r_lat);
        chk("sub 7-5 sum",  65'(r_sum),  65'd2);
        chk("sub 7-5 cout", 65'(r_cout), 65'd1);
        step();
        run_op(64'd7, 64'd5, 1'b1, 1'b0, r_sum, r_cout, r_lat);
        chk("add after sub", {r_cout, r_sum}, 65'd13);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
